// File: rtl/irq_ctrl.sv
// Fixed-priority interrupt controller feeding cp0's ir_in.
// Requests are synchronised, latched per source (edge or level mode), masked, and held until cp0 takes them.
module irq_ctrl #(
    parameter int N_SRC = 8,
    parameter int ID_W  = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_SRC-1:0] irq_src,
    input  logic             ir_taken,
    input  logic             eret,
    input  logic [1:0]       reg_addr,
    input  logic             reg_we,
    input  logic [31:0]      reg_wdata,
    output logic [31:0]      reg_rdata,
    output logic             ir_out,
    output logic [ID_W-1:0]  irq_id,
    output logic             in_service
);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_REQ     = 2'd1;
    localparam logic [1:0] ST_SERVICE = 2'd2;

    logic [N_SRC-1:0] sync1_r, sync2_r, dly_r;
    logic [N_SRC-1:0] mask_r, pending_r, edge_sel_r;
    logic [1:0]       state_r;

    logic [N_SRC-1:0] rise_s, eligible_s, w1c_s, taken_hit_s, es_chg_s, pending_nxt_s;
    logic [1:0]       state_nxt_s;
    logic             ir_out_nxt_s, in_service_nxt_s;
    logic [ID_W-1:0]  irq_id_nxt_s;
    logic [31:0]      rdata_s, status_s;

    function automatic logic [ID_W-1:0] pick_lowest(input logic [N_SRC-1:0] v);
        logic [ID_W-1:0] id;
        id = {ID_W{1'b0}};
        for (int i = N_SRC - 1; i >= 0; i--) begin
            if (v[i]) id = ID_W'(i);
        end
        return id;
    endfunction

    function automatic logic [31:0] zext(input logic [N_SRC-1:0] v);
        logic [31:0] r;
        r = 32'd0;
        for (int i = 0; i < N_SRC; i++) r[i] = v[i];
        return r;
    endfunction

    // Pending-bit update: edge bits set beats clear; a mode change on a bit wipes it.
    always_comb begin
        rise_s      = sync2_r & ~dly_r;
        eligible_s  = pending_r & mask_r;
        taken_hit_s = {N_SRC{1'b0}};
        if (ir_taken) begin
            taken_hit_s[irq_id] = 1'b1;
        end else begin
            taken_hit_s = {N_SRC{1'b0}};
        end
        if (reg_we && (reg_addr == 2'd1)) begin
            w1c_s = reg_wdata[N_SRC-1:0];
        end else begin
            w1c_s = {N_SRC{1'b0}};
        end
        if (reg_we && (reg_addr == 2'd2)) begin
            es_chg_s = reg_wdata[N_SRC-1:0] ^ edge_sel_r;
        end else begin
            es_chg_s = {N_SRC{1'b0}};
        end
        pending_nxt_s = ((edge_sel_r & ((pending_r & ~(w1c_s | taken_hit_s)) | rise_s))
                         | (~edge_sel_r & sync2_r)) & ~es_chg_s;
    end

    // Request FSM: identity is frozen once raised, no nesting while in service.
    always_comb begin
        state_nxt_s      = state_r;
        ir_out_nxt_s     = ir_out;
        in_service_nxt_s = in_service;
        irq_id_nxt_s     = irq_id;
        case (state_r)
            ST_IDLE: begin
                if (|eligible_s) begin
                    irq_id_nxt_s = pick_lowest(eligible_s);
                    ir_out_nxt_s = 1'b1;
                    state_nxt_s  = ST_REQ;
                end else begin
                    ir_out_nxt_s = 1'b0;
                end
            end
            ST_REQ: begin
                if (ir_taken) begin
                    ir_out_nxt_s     = 1'b0;
                    in_service_nxt_s = 1'b1;
                    state_nxt_s      = ST_SERVICE;
                end else if (!eligible_s[irq_id]) begin
                    ir_out_nxt_s = 1'b0;
                    state_nxt_s  = ST_IDLE;
                end else begin
                    ir_out_nxt_s = 1'b1;
                end
            end
            ST_SERVICE: begin
                if (eret) begin
                    in_service_nxt_s = 1'b0;
                    state_nxt_s      = ST_IDLE;
                end else begin
                    in_service_nxt_s = 1'b1;
                end
            end
            default: begin
                ir_out_nxt_s     = 1'b0;
                in_service_nxt_s = 1'b0;
                state_nxt_s      = ST_IDLE;
            end
        endcase
    end

    // Register read mux; the value is captured at the edge, so reads see pre-write contents.
    always_comb begin
        status_s                = 32'd0;
        status_s[ID_W-1:0]      = irq_id;
        status_s[ID_W]          = ir_out;
        status_s[ID_W+1]        = in_service;
        case (reg_addr)
            2'd0:    rdata_s = zext(mask_r);
            2'd1:    rdata_s = zext(pending_r);
            2'd2:    rdata_s = zext(edge_sel_r);
            2'd3:    rdata_s = status_s;
            default: rdata_s = 32'd0;
        endcase
    end

    // All state, with synchronous reset overriding any request or service in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_r    <= {N_SRC{1'b0}};
            sync2_r    <= {N_SRC{1'b0}};
            dly_r      <= {N_SRC{1'b0}};
            mask_r     <= {N_SRC{1'b0}};
            pending_r  <= {N_SRC{1'b0}};
            edge_sel_r <= {N_SRC{1'b0}};
            state_r    <= ST_IDLE;
            ir_out     <= 1'b0;
            in_service <= 1'b0;
            irq_id     <= {ID_W{1'b0}};
            reg_rdata  <= 32'd0;
        end else begin
            sync1_r    <= irq_src;
            sync2_r    <= sync1_r;
            dly_r      <= sync2_r;
            pending_r  <= pending_nxt_s;
            if (reg_we && (reg_addr == 2'd0)) mask_r <= reg_wdata[N_SRC-1:0];
            if (reg_we && (reg_addr == 2'd2)) edge_sel_r <= reg_wdata[N_SRC-1:0];
            state_r    <= state_nxt_s;
            ir_out     <= ir_out_nxt_s;
            in_service <= in_service_nxt_s;
            irq_id     <= irq_id_nxt_s;
            reg_rdata  <= rdata_s;
        end
    end

endmodule

// File: tb/tb_irq_ctrl.sv
// Scoreboard bench for irq_ctrl: stimulus queues expected reads and request ids,
// monitor pops them as reg_rdata returns and as ir_out rises.
module tb_irq_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  irq_src;
    logic        ir_taken, eret;
    logic [1:0]  reg_addr;
    logic        reg_we;
    logic [31:0] reg_wdata;
    logic [31:0] reg_rdata;
    logic        ir_out;
    logic [2:0]  irq_id;
    logic        in_service;

    typedef struct {
        string       name;
        logic [31:0] val;
    } exp_t;

    exp_t       exp_q[$];
    logic [2:0] req_q[$];
    int         checks = 0;
    int         failures = 0;
    logic       rd_en = 1'b0;
    logic       rd_vld = 1'b0;
    logic       ir_prev = 1'b0;

    irq_ctrl #(.N_SRC(8), .ID_W(3)) dut (
        .clk(clk), .rst(rst), .irq_src(irq_src), .ir_taken(ir_taken), .eret(eret),
        .reg_addr(reg_addr), .reg_we(reg_we), .reg_wdata(reg_wdata), .reg_rdata(reg_rdata),
        .ir_out(ir_out), .irq_id(irq_id), .in_service(in_service)
    );

    always #5 clk = ~clk;

    always @(posedge clk) rd_vld <= rd_en;

    // Monitor: compare read data and every new request against the scoreboard.
    always @(negedge clk) begin
        exp_t e;
        logic [2:0] id_e;
        if (rd_vld) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL rd_unexpected: got 0x%08h with no expected value queued", reg_rdata);
            end else begin
                e = exp_q.pop_front();
                if (reg_rdata !== e.val) begin
                    failures++;
                    $display("FAIL %s: got 0x%08h expected 0x%08h", e.name, reg_rdata, e.val);
                end
            end
        end
        if (ir_out === 1'b1 && ir_prev !== 1'b1) begin
            checks++;
            if (req_q.size() == 0) begin
                failures++;
                $display("FAIL req_unexpected: ir_out rose with irq_id=%0d, none expected", irq_id);
            end else begin
                id_e = req_q.pop_front();
                if (irq_id !== id_e) begin
                    failures++;
                    $display("FAIL req_id: got irq_id=%0d expected %0d", irq_id, id_e);
                end
            end
        end
        ir_prev = ir_out;
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        reg_addr  = a;
        reg_wdata = d;
        reg_we    = 1'b1;
        @(negedge clk);
        reg_we    = 1'b0;
    endtask

    task automatic rd(input logic [1:0] a, input logic [31:0] v, input string nm);
        exp_t e;
        e.name = nm;
        e.val  = v;
        exp_q.push_back(e);
        reg_addr = a;
        rd_en    = 1'b1;
        @(negedge clk);
        rd_en    = 1'b0;
    endtask

    task automatic pulse_taken();
        ir_taken = 1'b1;
        @(negedge clk);
        ir_taken = 1'b0;
    endtask

    task automatic pulse_eret();
        eret = 1'b1;
        @(negedge clk);
        eret = 1'b0;
    endtask

    initial begin
        #100000;
        failures++;
        $display("FAIL watchdog: time limit reached, got unfinished run expected completion");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; irq_src = 8'h00; ir_taken = 1'b0; eret = 1'b0;
        reg_addr = 2'd0; reg_we = 1'b0; reg_wdata = 32'd0;
        cyc(3);
        rst = 1'b0;
        rd(2'd3, 32'h0, "rst_status");
        rd(2'd1, 32'h0, "rst_pending");
        rd(2'd0, 32'h0, "rst_mask");
        rd(2'd2, 32'h0, "rst_edge_sel");
        wr(2'd0, 32'hFF);
        wr(2'd2, 32'hFF);
        rd(2'd2, 32'hFF, "edge_sel_rw");

        // 1: single edge request, latency, take and return
        req_q.push_back(3'd3);
        irq_src[3] = 1'b1;
        cyc(2);
        rd(2'd1, 32'h00, "t1_pend_t2");
        rd(2'd1, 32'h08, "t1_pend_t3");
        rd(2'd3, 32'h0B, "t1_status_req");
        pulse_taken();
        rd(2'd3, 32'h13, "t1_status_service");
        rd(2'd1, 32'h00, "t1_pend_taken");
        pulse_eret();
        rd(2'd3, 32'h03, "t1_status_eret");
        irq_src[3] = 1'b0;
        cyc(4);

        // 2: priority, eret ignored in REQ, follow-on request
        req_q.push_back(3'd1);
        req_q.push_back(3'd5);
        irq_src[1] = 1'b1; irq_src[5] = 1'b1;
        cyc(4);
        pulse_eret();
        rd(2'd3, 32'h09, "t2_eret_in_req");
        pulse_taken();
        rd(2'd1, 32'h20, "t2_pend_service");
        pulse_eret();
        rd(2'd3, 32'h01, "t2_status_idle");
        rd(2'd3, 32'h0D, "t2_status_req5");
        pulse_taken();
        pulse_eret();
        irq_src[1] = 1'b0; irq_src[5] = 1'b0;
        cyc(4);

        // 3: masked source stays pending, unmask raises it
        wr(2'd0, 32'hDF);
        irq_src[5] = 1'b1;
        cyc(23);
        rd(2'd1, 32'h20, "t3_pend_masked");
        rd(2'd3, 32'h05, "t3_status_masked");
        req_q.push_back(3'd5);
        wr(2'd0, 32'hFF);
        cyc(1);
        rd(2'd3, 32'h0D, "t3_status_unmask");
        pulse_taken();
        pulse_eret();
        irq_src[5] = 1'b0;
        cyc(4);
        rd(2'd0, 32'hFF, "t3_mask_rw");

        // 4: level mode re-raise, then drop during service
        wr(2'd2, 32'hFB);
        req_q.push_back(3'd2);
        irq_src[2] = 1'b1;
        cyc(4);
        pulse_taken();
        rd(2'd3, 32'h12, "t4_status_service");
        req_q.push_back(3'd2);
        pulse_eret();
        cyc(2);
        rd(2'd3, 32'h0A, "t4_status_reraise");
        pulse_taken();
        irq_src[2] = 1'b0;
        cyc(4);
        rd(2'd1, 32'h00, "t4_pend_dropped");
        pulse_eret();
        cyc(5);
        rd(2'd3, 32'h02, "t4_status_quiet");

        // 5: W1C withdraws a raised request
        wr(2'd2, 32'hFF);
        req_q.push_back(3'd4);
        irq_src[4] = 1'b1;
        cyc(4);
        wr(2'd1, 32'h10);
        rd(2'd3, 32'h0C, "t5_status_w1c_edge");
        rd(2'd3, 32'h04, "t5_status_withdrawn");
        rd(2'd1, 32'h00, "t5_pend_cleared");
        irq_src[4] = 1'b0;
        cyc(4);

        // 6: reset during service with pending sources
        req_q.push_back(3'd0);
        irq_src[0] = 1'b1; irq_src[7] = 1'b1;
        cyc(4);
        pulse_taken();
        irq_src[0] = 1'b0;
        cyc(3);
        irq_src[0] = 1'b1;
        cyc(3);
        rd(2'd1, 32'h81, "t6_pend_service");
        rd(2'd3, 32'h10, "t6_status_service");
        rst = 1'b1;
        cyc(2);
        rst = 1'b0;
        rd(2'd3, 32'h0, "t6_rst_status");
        rd(2'd1, 32'h0, "t6_rst_pending");
        rd(2'd0, 32'h0, "t6_rst_mask");
        rd(2'd2, 32'h0, "t6_rst_edge_sel");
        irq_src = 8'h00;
        cyc(10);

        checks++;
        if (req_q.size() != 0) begin
            failures++;
            $display("FAIL req_left: got %0d outstanding requests expected 0", req_q.size());
        end
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL rd_left: got %0d outstanding reads expected 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
